// File: rtl/pid_sched_pkg.sv
// Shared definitions for the PID axis scheduler: state encoding, index width,
// default wait budget and the operand bundle handed to the shared PID.
package pid_sched_pkg;

    localparam int unsigned AXIS_IDX_W      = 2;
    localparam int unsigned MAX_AXES        = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam int unsigned WORD_W          = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t sp;
        word_t pv;
        word_t kp;
        word_t ki;
        word_t kd;
    } pid_ops_t;

endpackage

// File: rtl/pid_axis_pick.sv
// Lowest-set-bit picker: returns the index of the least significant set bit
// of the mask and whether any bit was set at all.
module pid_axis_pick
    import pid_sched_pkg::*;
#(
    parameter int unsigned NUM_AXES = 2
)(
    input  logic [NUM_AXES-1:0]   mask,
    output logic [AXIS_IDX_W-1:0] index,
    output logic                  found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned n = 0; n < NUM_AXES; n++) begin
            if (mask[NUM_AXES-1-n]) begin
                index = AXIS_IDX_W'(NUM_AXES - 1 - n);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pid_axis_scheduler.sv
// Time-multiplexes one PID datapath across NUM_AXES axes: each sample tick
// walks the enabled axes lowest-first, issues operands, and collects results.
module pid_axis_scheduler
    import pid_sched_pkg::*;
#(
    parameter int unsigned NUM_AXES = 2,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
)(
    input  logic                    i_clk_sp,
    input  logic                    i_rst,
    input  logic                    i_tick,
    input  logic [NUM_AXES-1:0]     i_en,
    input  logic [NUM_AXES*16-1:0]  i_sp,
    input  logic [NUM_AXES*16-1:0]  i_pv,
    input  logic [NUM_AXES*16-1:0]  i_kp,
    input  logic [NUM_AXES*16-1:0]  i_ki,
    input  logic [NUM_AXES*16-1:0]  i_kd,
    input  logic                    i_clr_flags,
    output logic [15:0]             o_pid_sp,
    output logic [15:0]             o_pid_pv,
    output logic [15:0]             o_pid_kp,
    output logic [15:0]             o_pid_ki,
    output logic [15:0]             o_pid_kd,
    output logic                    o_pid_start,
    input  logic [15:0]             i_pid_un,
    input  logic                    i_pid_valid,
    output logic [NUM_AXES*16-1:0]  o_un,
    output logic                    o_un_valid,
    output logic [AXIS_IDX_W-1:0]   o_un_axis,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic [NUM_AXES-1:0]     o_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]            state_q;
    logic [NUM_AXES-1:0]   mask_q;
    logic [NUM_AXES-1:0]   mask_rem;
    logic [NUM_AXES-1:0]   pick_mask;
    logic [AXIS_IDX_W-1:0] axis_q;
    logic [AXIS_IDX_W-1:0] pick_idx;
    logic                  pick_found;
    logic [CNT_W-1:0]      cnt_q;
    pid_ops_t              ops_q;
    pid_ops_t              sel_ops;
    logic                  timeout_hit;
    logic                  overrun_set;
    logic [NUM_AXES-1:0]   fault_set;

    assign o_pid_sp = ops_q.sp;
    assign o_pid_pv = ops_q.pv;
    assign o_pid_kp = ops_q.kp;
    assign o_pid_ki = ops_q.ki;
    assign o_pid_kd = ops_q.kd;
    assign o_busy   = (state_q != ST_IDLE);

    assign timeout_hit = (state_q == ST_WAIT) && !i_pid_valid &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
    assign overrun_set = i_tick && (state_q != ST_IDLE);

    always_comb begin
        sel_ops = '0;
        for (int unsigned n = 0; n < NUM_AXES; n++) begin
            if (axis_q == AXIS_IDX_W'(n)) begin
                sel_ops.sp = i_sp[16*n +: 16];
                sel_ops.pv = i_pv[16*n +: 16];
                sel_ops.kp = i_kp[16*n +: 16];
                sel_ops.ki = i_ki[16*n +: 16];
                sel_ops.kd = i_kd[16*n +: 16];
            end
        end
    end

    always_comb begin
        mask_rem  = mask_q;
        fault_set = '0;
        for (int unsigned n = 0; n < NUM_AXES; n++) begin
            if (axis_q == AXIS_IDX_W'(n)) begin
                mask_rem[n]  = 1'b0;
                fault_set[n] = timeout_hit;
            end
        end
    end

    // One picker serves both the round start (from i_en) and the advance
    // out of STORE (from the remaining mask).
    assign pick_mask = (state_q == ST_IDLE) ? i_en : mask_rem;

    pid_axis_pick #(
        .NUM_AXES (NUM_AXES)
    ) u_pick (
        .mask  (pick_mask),
        .index (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge i_clk_sp or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            axis_q      <= '0;
            cnt_q       <= '0;
            ops_q       <= '0;
            o_pid_start <= 1'b0;
            o_un        <= '0;
            o_un_valid  <= 1'b0;
            o_un_axis   <= '0;
        end else begin
            o_pid_start <= 1'b0;
            o_un_valid  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tick && pick_found) begin
                        mask_q  <= i_en;
                        axis_q  <= pick_idx;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    ops_q       <= sel_ops;
                    o_pid_start <= 1'b1;
                    state_q     <= ST_START;
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Result is published on entry to STORE so the strobe
                    // lands one cycle after i_pid_valid.
                    if (i_pid_valid) begin
                        for (int unsigned n = 0; n < NUM_AXES; n++) begin
                            if (axis_q == AXIS_IDX_W'(n)) begin
                                o_un[16*n +: 16] <= i_pid_un;
                            end
                        end
                        o_un_valid <= 1'b1;
                        o_un_axis  <= axis_q;
                        state_q    <= ST_STORE;
                    end else if (timeout_hit) begin
                        state_q <= ST_STORE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (pick_found) begin
                        mask_q  <= mask_rem;
                        axis_q  <= pick_idx;
                        state_q <= ST_SETUP;
                    end else begin
                        mask_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes precedence.
    always_ff @(posedge i_clk_sp or posedge i_rst) begin
        if (i_rst) begin
            o_overrun <= 1'b0;
            o_fault   <= '0;
        end else begin
            o_overrun <= (o_overrun && !i_clr_flags) || overrun_set;
            o_fault   <= (o_fault & ~{NUM_AXES{i_clr_flags}}) | fault_set;
        end
    end

endmodule
